bus_rr_ctrl: RTL
================

BUS_RR_CTRL -- requirements
Module: bus_rr_ctrl

Interface
REQ-001 SHALL have parameter MAX_TENURE, default 16: max cycles one master may hold the bus while another requests.
REQ-002 SHALL have parameter TIMEOUT, default 32: max cycles to wait for bus_rdy after address strobe.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rest  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports m0_req..m3_req  input  1 each  bus request from masters 0-3.
REQ-006 SHALL have ports m0_grnt..m3_grnt  output  1 each  registered grant, at most one high.
REQ-007 SHALL have port bus_as  input  1  address strobe of the muxed (granted) master.
REQ-008 SHALL have port bus_rdy  input  1  muxed slave ready.
REQ-009 SHALL have port bus_err  output  1  one-cycle pulse on transfer timeout.
REQ-010 SHALL have port owner  output  2  index of current or last granted master.
REQ-011 SHALL have port busy  output  1  high while any grant is asserted.

Function
REQ-012 SHALL implement FSM states IDLE (no grant), OWNED (grant held, no transfer), WAIT_RDY (transfer in flight).
REQ-013 Arbitration SHALL be round-robin: search starts at owner+1 mod 4 and wraps; first requesting master wins.
REQ-014 IDLE: req sampled high at edge k -> winner grant high after edge k (one-cycle latency); state -> OWNED, owner updated.
REQ-015 OWNED, owner req low at edge: grant passes at that same edge to next round-robin requester (no idle bubble); if none, all grants low, -> IDLE.
REQ-016 OWNED, bus_as high at edge: -> WAIT_RDY, timeout counter cleared to 0.
REQ-017 WAIT_RDY: grant SHALL NOT change regardless of req; counter increments each cycle bus_rdy low.
REQ-018 WAIT_RDY, bus_rdy high at edge: -> OWNED; rdy in the same cycle counter reaches TIMEOUT-1 SHALL count as success (rdy wins).
REQ-019 WAIT_RDY, counter reaches TIMEOUT-1 with bus_rdy low: bus_err high for exactly next cycle, all grants dropped, -> IDLE; owner retained so offender gets lowest priority next.
REQ-020 Tenure counter SHALL clear on every new grant, increment each cycle in OWNED or WAIT_RDY, saturate at MAX_TENURE.
REQ-021 Tenure saturated and any other master requesting: in OWNED, grant SHALL pass at next edge to next round-robin requester even if owner req still high; never preempt in WAIT_RDY.
REQ-022 Tenure saturated, no other requester: owner SHALL keep grant indefinitely.
REQ-023 Single requester after own release SHALL be re-granted (search wraps to itself last).
REQ-024 Timeout counter width SHALL be clog2(TIMEOUT)+1; tenure width clog2(MAX_TENURE)+1; no wrap permitted.
REQ-025 busy SHALL equal OR of all grants, registered with them.

Reset
REQ-026 rest low SHALL immediately (asynchronously) force: all grants 0, bus_err 0, busy 0, owner 2'd3, state IDLE, both counters 0.
REQ-027 owner reset value 3 SHALL give m0 highest priority at first arbitration.
REQ-028 Reset asserted in WAIT_RDY SHALL abort without bus_err pulse; release of rest takes effect at next rising edge.

Verification
REQ-029 After reset, m0..m3 req all high same cycle -> m0_grnt high one cycle later, owner=0.
REQ-030 m0 owner drops req, m2 and m3 requesting -> same edge m2_grnt high, m0_grnt low, no cycle with busy=0.
REQ-031 m1 holds req 20 cycles, no as, m3 requests at cycle 5 -> m1 grant revoked after 16 cycles of tenure, m3_grnt next.
REQ-032 bus_as pulse, bus_rdy never -> bus_err high one cycle after 32 cycles in WAIT_RDY, all grants 0, state IDLE.
REQ-033 bus_rdy arriving on cycle 31 of WAIT_RDY -> no bus_err, grant retained, state OWNED.
REQ-034 rest pulsed low mid WAIT_RDY -> grants 0 immediately, bus_err stays 0, owner=3.

Source files
------------

// File: rtl/bus_rr_ctrl_if.sv
// Request/grant and transfer handshake bundle between four bus masters and the
// round-robin bus controller; the controller attaches through the slave modport.
interface bus_rr_ctrl_if;
    logic       m0_req;
    logic       m1_req;
    logic       m2_req;
    logic       m3_req;
    logic       m0_grnt;
    logic       m1_grnt;
    logic       m2_grnt;
    logic       m3_grnt;
    logic       bus_as;
    logic       bus_rdy;
    logic       bus_err;
    logic [1:0] owner;
    logic       busy;

    modport master (
        output m0_req, m1_req, m2_req, m3_req, bus_as, bus_rdy,
        input  m0_grnt, m1_grnt, m2_grnt, m3_grnt, bus_err, owner, busy
    );

    modport slave (
        input  m0_req, m1_req, m2_req, m3_req, bus_as, bus_rdy,
        output m0_grnt, m1_grnt, m2_grnt, m3_grnt, bus_err, owner, busy
    );
endinterface

// File: rtl/bus_rr_ctrl.sv
// Four-master round-robin bus arbiter with tenure-limited ownership and a
// transfer watchdog that drops the grant when the slave never becomes ready.
module bus_rr_ctrl #(
    parameter int MAX_TENURE = 16,
    parameter int TIMEOUT    = 32
) (
    input  logic          clk,
    input  logic          rest,
    bus_rr_ctrl_if.slave  bus
);
    localparam int TOUT_W = $clog2(TIMEOUT) + 1;
    localparam int TEN_W  = $clog2(MAX_TENURE) + 1;
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);
    localparam logic [TEN_W-1:0]  TEN_MAX   = TEN_W'(MAX_TENURE);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        WAIT_RDY
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [3:0]        r_grant;
    logic [3:0]        w_grantNext;
    logic [1:0]        r_owner;
    logic [1:0]        w_ownerNext;
    logic              r_busy;
    logic              r_err;
    logic              w_errNext;
    logic [TOUT_W-1:0] r_tout;
    logic [TOUT_W-1:0] w_toutNext;
    logic [TEN_W-1:0]  r_tenure;
    logic [TEN_W-1:0]  w_tenureNext;
    logic [TEN_W-1:0]  w_tenureInc;

    logic [3:0]        w_req;
    logic [1:0]        w_o1;
    logic [1:0]        w_o2;
    logic [1:0]        w_o3;
    logic              w_otherValid;
    logic [1:0]        w_otherIdx;
    logic              w_anyValid;
    logic [1:0]        w_anyIdx;

    assign w_req = {bus.m3_req, bus.m2_req, bus.m1_req, bus.m0_req};
    assign w_o1  = r_owner + 2'd1;
    assign w_o2  = r_owner + 2'd2;
    assign w_o3  = r_owner + 2'd3;

    // Search order is owner+1, +2, +3 and finally the owner itself, so the
    // "other" winner is the preemption candidate and the owner only wins last.
    always_comb begin
        w_otherValid = 1'b1;
        w_otherIdx   = w_o1;
        if (w_req[w_o1]) begin
            w_otherIdx = w_o1;
        end else if (w_req[w_o2]) begin
            w_otherIdx = w_o2;
        end else if (w_req[w_o3]) begin
            w_otherIdx = w_o3;
        end else begin
            w_otherValid = 1'b0;
            w_otherIdx   = r_owner;
        end
        w_anyValid = w_otherValid | w_req[r_owner];
        w_anyIdx   = w_otherValid ? w_otherIdx : r_owner;
    end

    assign w_tenureInc = (r_tenure == TEN_MAX) ? r_tenure : r_tenure + TEN_W'(1);

    always_comb begin
        w_stateNext  = r_state;
        w_grantNext  = r_grant;
        w_ownerNext  = r_owner;
        w_errNext    = 1'b0;
        w_toutNext   = r_tout;
        w_tenureNext = r_tenure;
        case (r_state)
            IDLE: begin
                w_tenureNext = '0;
                w_toutNext   = '0;
                if (w_anyValid) begin
                    w_grantNext = 4'b0001 << w_anyIdx;
                    w_ownerNext = w_anyIdx;
                    w_stateNext = OWNED;
                end
            end
            OWNED: begin
                if (!w_req[r_owner]) begin
                    w_tenureNext = '0;
                    if (w_otherValid) begin
                        w_grantNext = 4'b0001 << w_otherIdx;
                        w_ownerNext = w_otherIdx;
                    end else begin
                        w_grantNext = 4'b0000;
                        w_stateNext = IDLE;
                    end
                end else if ((r_tenure == TEN_MAX) && w_otherValid) begin
                    w_tenureNext = '0;
                    w_grantNext  = 4'b0001 << w_otherIdx;
                    w_ownerNext  = w_otherIdx;
                end else begin
                    w_tenureNext = w_tenureInc;
                    if (bus.bus_as) begin
                        w_stateNext = WAIT_RDY;
                        w_toutNext  = '0;
                    end
                end
            end
            WAIT_RDY: begin
                // Ready on the final watchdog cycle still counts as a completed transfer.
                w_tenureNext = w_tenureInc;
                if (bus.bus_rdy) begin
                    w_stateNext = OWNED;
                end else if (r_tout == TOUT_LAST) begin
                    w_errNext   = 1'b1;
                    w_grantNext = 4'b0000;
                    w_toutNext  = '0;
                    w_stateNext = IDLE;
                end else begin
                    w_toutNext = r_tout + TOUT_W'(1);
                end
            end
            default: begin
                w_grantNext = 4'b0000;
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state  <= IDLE;
            r_grant  <= 4'b0000;
            r_owner  <= 2'd3;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_tout   <= '0;
            r_tenure <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_grant  <= w_grantNext;
            r_owner  <= w_ownerNext;
            r_busy   <= |w_grantNext;
            r_err    <= w_errNext;
            r_tout   <= w_toutNext;
            r_tenure <= w_tenureNext;
        end
    end

    assign bus.m0_grnt = r_grant[0];
    assign bus.m1_grnt = r_grant[1];
    assign bus.m2_grnt = r_grant[2];
    assign bus.m3_grnt = r_grant[3];
    assign bus.owner   = r_owner;
    assign bus.busy    = r_busy;
    assign bus.bus_err = r_err;
endmodule
